// File: rtl/fib_index_finder.sv
// fib_index_finder: inverse of the Fibonacci unit. Given a value, walks the
// sequence F(0)=1, F(1)=1, F(2)=2, ... one term per clock and reports the
// index N with F(N) == value, using a start/done handshake.
// Optional build macro FIB_FLOOR_EN: on a miss, N reports the floor index
// (last index whose term stayed below value) instead of 0.
module fib_index_finder #(
    parameter int VW = 5,
    parameter int IW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [VW-1:0] value,
    output logic [IW-1:0] N,
    output logic          found,
    output logic          done,
    output logic          busy
);

    localparam logic STATE_IDLE   = 1'b0;
    localparam logic STATE_SEARCH = 1'b1;

    localparam logic [IW-1:0] MAXIDX  = '1;
    localparam logic [IW-1:0] IDX_ONE = {{(IW-1){1'b0}}, 1'b1};
    localparam logic [VW:0]   TERM_ONE = {{VW{1'b0}}, 1'b1};

    logic          state;
    logic [VW:0]   term_a;
    logic [VW:0]   term_b;
    logic [IW-1:0] idx;
    logic [VW-1:0] value_q;

    logic [VW+1:0] term_sum;
    logic [VW:0]   next_b;
    logic          hit;
    logic          over;
    logic          last;
    logic [IW-1:0] miss_n;

    // Next term with saturation; a saturated term only ever compares as
    // larger than any value, which terminates the search correctly.
    always_comb begin
        term_sum = {1'b0, term_a} + {1'b0, term_b};
        next_b   = term_sum[VW+1] ? '1 : term_sum[VW:0];
        hit      = (term_a == {1'b0, value_q});
        over     = (term_a > {1'b0, value_q});
        last     = (idx == MAXIDX);
`ifdef FIB_FLOOR_EN
        if (over) begin
            miss_n = (idx == '0) ? '0 : (idx - IDX_ONE);
        end else begin
            miss_n = idx;
        end
`else
        miss_n = '0;
`endif
    end

    // Handshake and search FSM: accept in IDLE, one compare per clock in SEARCH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= STATE_IDLE;
            term_a  <= TERM_ONE;
            term_b  <= TERM_ONE;
            idx     <= '0;
            value_q <= '0;
            N       <= '0;
            found   <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state)
                STATE_IDLE: begin
                    if (start) begin
                        value_q <= value;
                        term_a  <= TERM_ONE;
                        term_b  <= TERM_ONE;
                        idx     <= '0;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        found   <= 1'b0;
                        N       <= '0;
                        state   <= STATE_SEARCH;
                    end
                end
                STATE_SEARCH: begin
                    if (hit) begin
                        N     <= idx;
                        found <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= STATE_IDLE;
                    end else if (over || last) begin
                        N     <= miss_n;
                        found <= 1'b0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= STATE_IDLE;
                    end else begin
                        term_a <= term_b;
                        term_b <= next_b;
                        idx    <= idx + IDX_ONE;
                    end
                end
                default: begin
                    state <= STATE_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fib_index_finder.sv
// tb_fib_index_finder: directed checks of fib_index_finder against
// hand-computed indices and latencies. Expected miss indices follow the
// FIB_FLOOR_EN build macro.
module tb_fib_index_finder;

    logic       clk;
    logic       rst;
    logic       start;
    logic [4:0] value;
    logic [2:0] N;
    logic       found;
    logic       done;
    logic       busy;

    int errors = 0;
    int checks = 0;

    fib_index_finder #(.VW(5), .IW(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .value (value),
        .N     (N),
        .found (found),
        .done  (done),
        .busy  (busy)
    );

    // Free-running clock, 10 time-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Launch a search and count edges until done; optional start noise while busy
    task automatic do_search(input logic [4:0] v, input bit noise, output int cycles);
        @(negedge clk);
        value = v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cycles = 0;
        while (cycles < 20) begin
            @(negedge clk);
            if (noise && cycles < 3) begin
                start = 1'b1;
                value = 5'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            cycles++;
            if (done) break;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst   = 1'b0;
        start = 1'b0;
        value = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({N, found, done, busy} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b expected 000000", {N, found, done, busy});
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_match;
        int cyc;
        do_search(5'd13, 1'b0, cyc);
        checks++;
        if (cyc !== 7) begin errors++; $display("[TB] FAIL v13_latency: got %0d expected 7", cyc); end
        checks++;
        if (N !== 3'd6 || found !== 1'b1 || done !== 1'b1) begin
            errors++; $display("[TB] FAIL v13_result: got N=%0d found=%0b done=%0b expected N=6 found=1 done=1", N, found, done);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL v13_busy: got %0b expected 0", busy); end
    endtask

    task automatic test_ambiguous_and_max;
        int cyc;
        do_search(5'd1, 1'b0, cyc);
        checks++;
        if (cyc !== 1 || N !== 3'd0 || found !== 1'b1) begin
            errors++; $display("[TB] FAIL v1: got cyc=%0d N=%0d found=%0b expected cyc=1 N=0 found=1", cyc, N, found);
        end
        do_search(5'd21, 1'b0, cyc);
        checks++;
        if (cyc !== 8 || N !== 3'd7 || found !== 1'b1) begin
            errors++; $display("[TB] FAIL v21: got cyc=%0d N=%0d found=%0b expected cyc=8 N=7 found=1", cyc, N, found);
        end
    endtask

    task automatic test_miss;
        int cyc;
        logic [2:0] exp4;
        logic [2:0] exp30;
`ifdef FIB_FLOOR_EN
        exp4  = 3'd3;
        exp30 = 3'd7;
`else
        exp4  = 3'd0;
        exp30 = 3'd0;
`endif
        do_search(5'd4, 1'b0, cyc);
        checks++;
        if (cyc !== 5 || found !== 1'b0 || done !== 1'b1) begin
            errors++; $display("[TB] FAIL v4_handshake: got cyc=%0d found=%0b done=%0b expected cyc=5 found=0 done=1", cyc, found, done);
        end
        checks++;
        if (N !== exp4) begin errors++; $display("[TB] FAIL v4_index: got %0d expected %0d", N, exp4); end
        do_search(5'd30, 1'b0, cyc);
        checks++;
        if (cyc !== 8 || found !== 1'b0) begin
            errors++; $display("[TB] FAIL v30_handshake: got cyc=%0d found=%0b expected cyc=8 found=0", cyc, found);
        end
        checks++;
        if (N !== exp30) begin errors++; $display("[TB] FAIL v30_index: got %0d expected %0d", N, exp30); end
        do_search(5'd0, 1'b0, cyc);
        checks++;
        if (cyc !== 1 || found !== 1'b0 || N !== 3'd0) begin
            errors++; $display("[TB] FAIL v0: got cyc=%0d N=%0d found=%0b expected cyc=1 N=0 found=0", cyc, N, found);
        end
    endtask

    task automatic test_ignore_start;
        int cyc;
        do_search(5'd8, 1'b1, cyc);
        checks++;
        if (cyc !== 6 || N !== 3'd5 || found !== 1'b1) begin
            errors++; $display("[TB] FAIL v8_noise: got cyc=%0d N=%0d found=%0b expected cyc=6 N=5 found=1", cyc, N, found);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (N !== 3'd5 || done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("[TB] FAIL v8_hold: got N=%0d done=%0b busy=%0b expected N=5 done=1 busy=0", N, done, busy);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        value = 5'd1;
        start = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1 || found !== 1'b1) begin
            errors++; $display("[TB] FAIL b2b_first: got done=%0b found=%0b expected done=1 found=1", done, found);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("[TB] FAIL b2b_relaunch: got done=%0b busy=%0b expected done=0 busy=1", done, busy);
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1 || N !== 3'd0) begin
            errors++; $display("[TB] FAIL b2b_second: got done=%0b N=%0d expected done=1 N=0", done, N);
        end
    endtask

    task automatic test_abort;
        int cyc;
        @(negedge clk);
        value = 5'd21;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({N, found, done, busy} !== 6'b0) begin
            errors++; $display("[TB] FAIL abort_async: got %b expected 000000", {N, found, done, busy});
        end
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("[TB] FAIL abort_hold: got done=%0b busy=%0b expected 0 0", done, busy);
        end
        @(negedge clk);
        rst = 1'b1;
        do_search(5'd5, 1'b0, cyc);
        checks++;
        if (cyc !== 5 || N !== 3'd4 || found !== 1'b1) begin
            errors++; $display("[TB] FAIL after_abort: got cyc=%0d N=%0d found=%0b expected cyc=5 N=4 found=1", cyc, N, found);
        end
    endtask

    // Scenario sequence followed by the summary line
    initial begin
        test_reset();
        test_match();
        test_ambiguous_and_max();
        test_miss();
        test_ignore_start();
        test_back_to_back();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
